// File: rtl/fsm_step_sequencer.sv
// fsm_step_sequencer: steps a serial x pattern into the 3-state x-detector FSM.
// The block sends one clk_en pulse per step and samples the FSM's Mealy output
// on that step. It counts the steps whose output equals MATCH.
module fsm_step_sequencer #(
  parameter int         PAT_W = 16,
  parameter int         LEN_W = 5,
  parameter int         GAP_W = 4,
  parameter logic [1:0] MATCH = 2'b01
) (
  input  logic             clk_out,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] run_len,
  input  logic [GAP_W-1:0] step_gap,
  input  logic [1:0]       o_in,
  output logic             x_out,
  output logic             fsm_en,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] step_idx,
  output logic [LEN_W-1:0] hit_count,
  output logic [1:0]       last_o
);

  localparam int               IDX_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic             x_hold_q;

  logic [LEN_W-1:0] len_clamp;
  logic [LEN_W-1:0] step_nxt;
  logic             drive_bit;

  assign len_clamp = (run_len > MAX_LEN) ? MAX_LEN : run_len;
  assign step_nxt  = step_idx + LEN_W'(1);
  assign drive_bit = pat_q[step_idx[IDX_W-1:0]];

  // State register.
  always_ff @(posedge clk_out or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and output decode.
  always_comb begin
    // NOTE: every output gets a default first, so no path through the case
    // can leave a variable unassigned and infer a latch.
    state_d = state_q;
    fsm_en  = 1'b0;
    done    = 1'b0;
    x_out   = 1'b0;
    busy    = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start) state_d = (len_clamp == '0) ? S_DONE : S_DRIVE;
      end
      S_DRIVE: begin
        fsm_en = 1'b1;
        x_out  = drive_bit;
        // The trailing gap also follows the last step, so every step spans
        // 1+gap cycles and done lands at 1+L*(1+gap).
        if (gap_q != '0)           state_d = S_WAIT;
        else if (step_nxt == len_q) state_d = S_DONE;
        else                        state_d = S_DRIVE;
      end
      S_WAIT: begin
        x_out = x_hold_q;
        if (gap_cnt_q == GAP_W'(1))
          state_d = (step_idx == len_q) ? S_DONE : S_DRIVE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything. It also masks the pulses, so the FSM never
    // sees a clk_en on a step that is being dropped.
    if (abort) begin
      state_d = S_IDLE;
      fsm_en  = 1'b0;
      done    = 1'b0;
    end
  end

  // Run configuration, step counters and sampled FSM output.
  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      pat_q     <= '0;
      len_q     <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      x_hold_q  <= 1'b0;
      step_idx  <= '0;
      hit_count <= '0;
      last_o    <= '0;
    end else if (!abort) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pat_q     <= pattern;
            len_q     <= len_clamp;
            gap_q     <= step_gap;
            step_idx  <= '0;
            hit_count <= '0;
          end
        end
        S_DRIVE: begin
          // o_in is the Mealy output for the current FSM state and x_out.
          // It is taken on the same edge that lets the FSM advance.
          last_o    <= o_in;
          if (o_in == MATCH) hit_count <= hit_count + LEN_W'(1);
          step_idx  <= step_nxt;
          x_hold_q  <= drive_bit;
          gap_cnt_q <= gap_q;
        end
        S_WAIT: begin
          gap_cnt_q <= gap_cnt_q - GAP_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_step_sequencer.sv
// tb_fsm_step_sequencer: directed runs with a scoreboard of expected pulses.
// A small x-detector FSM model can be looped back for the closed-loop run.
module tb_fsm_step_sequencer;

  logic        clk_out = 1'b0;
  logic        reset, start, abort;
  logic [15:0] pattern;
  logic [4:0]  run_len;
  logic [3:0]  step_gap;
  logic [1:0]  o_in;
  logic        x_out, fsm_en, busy, done;
  logic [4:0]  step_idx, hit_count;
  logic [1:0]  last_o;

  fsm_step_sequencer dut (
    .clk_out  (clk_out),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .pattern  (pattern),
    .run_len  (run_len),
    .step_gap (step_gap),
    .o_in     (o_in),
    .x_out    (x_out),
    .fsm_en   (fsm_en),
    .busy     (busy),
    .done     (done),
    .step_idx (step_idx),
    .hit_count(hit_count),
    .last_o   (last_o)
  );

  always #5 clk_out = ~clk_out;

  // Expected pulse: fsm_en (is_done=0) or done (is_done=1); -1 skips a field.
  typedef struct {
    bit is_done;
    int cyc;
    int x;
    int idx;
    int hit;
    int o;
    int lo;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   t0 = 0;
  int   busy_cycles = 0;
  int   hold_x = 0;

  // Environment model of the 3-state x-detector FSM (Mealy output o).
  typedef enum logic [1:0] {F0, F1, F2} fst_t;
  fst_t       fst, fst_nxt;
  logic [1:0] fsm_o;
  logic [1:0] o_force;
  logic       loop_mode, fsm_rst;

  always_comb begin
    fst_nxt = fst;
    fsm_o   = 2'b00;
    case (fst)
      F0: fst_nxt = x_out ? F1 : F0;
      F1: if (!x_out) begin fsm_o = 2'b01; fst_nxt = F2; end
          else fst_nxt = F1;
      F2: if (x_out) begin fsm_o = 2'b10; fst_nxt = F1; end
          else fst_nxt = F0;
      default: fst_nxt = F0;
    endcase
  end

  always @(posedge clk_out or posedge fsm_rst)
    if (fsm_rst) fst <= F0;
    else if (fsm_en) fst <= fst_nxt;

  assign o_in = loop_mode ? fsm_o : o_force;

  always @(posedge clk_out) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int want);
    n_checks++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
  endtask

  function automatic void push_en(int k, int x, int idx, int hit, int o, int lo);
    sb_q.push_back('{is_done: 1'b0, cyc: t0 + k, x: x, idx: idx, hit: hit, o: o, lo: lo});
  endfunction

  function automatic void push_done(int k, int idx, int hit, int lo);
    sb_q.push_back('{is_done: 1'b1, cyc: t0 + k, x: 0, idx: idx, hit: hit, o: -1, lo: lo});
  endfunction

  // Monitor: pops one expectation per fsm_en/done pulse and checks the x_out hold in WAIT.
  always @(negedge clk_out) begin
    if (!reset) begin
      if (busy) busy_cycles++;
      if (fsm_en || done) begin
        if (sb_q.size() == 0) begin
          check(fsm_en ? "unexpected_fsm_en" : "unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("pulse_kind", int'(done), int'(e.is_done));
          check("pulse_cycle", cyc - t0, e.cyc - t0);
          check("step_idx", int'(step_idx), e.idx);
          check("hit_count", int'(hit_count), e.hit);
          if (e.lo >= 0) check("last_o", int'(last_o), e.lo);
          if (fsm_en) begin
            check("x_out_drive", int'(x_out), e.x);
            if (e.o >= 0) check("o_in_step", int'(o_in), e.o);
            hold_x = e.x;
          end else begin
            check("x_out_done", int'(x_out), 0);
          end
        end
      end else if (busy) begin
        check("x_out_wait_hold", int'(x_out), hold_x);
      end else begin
        check("x_out_idle", int'(x_out), 0);
      end
    end
  end

  task automatic begin_run(input logic [15:0] p, input logic [4:0] l, input logic [3:0] g);
    @(negedge clk_out);
    pattern     = p;
    run_len     = l;
    step_gap    = g;
    abort       = 1'b0;
    start       = 1'b1;
    t0          = cyc;
    busy_cycles = 0;
  endtask

  // Drops start, scrambles the inputs that were latched at start, and waits for idle.
  task automatic finish_run(input int budget);
    @(negedge clk_out);
    start    = 1'b0;
    pattern  = ~pattern;
    run_len  = 5'd1;
    step_gap = 4'd7;
    for (int i = 0; i < budget && busy; i++) @(negedge clk_out);
    check("run_terminates", int'(busy), 0);
  endtask

  initial begin
    logic [15:0] p;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] p;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    pattern = '0; run_len = '0; step_gap = '0;
    o_force = 2'b00; loop_mode = 1'b0; fsm_rst = 1'b1;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_fsm_en", int'(fsm_en), 0);
    check("rst_done", int'(done), 0);
    check("rst_x_out", int'(x_out), 0);
    check("rst_step_idx", int'(step_idx), 0);
    check("rst_hit_count", int'(hit_count), 0);
    check("rst_last_o", int'(last_o), 0);
    repeat (2) @(negedge clk_out);
    reset = 1'b0; fsm_rst = 1'b0;
    @(negedge clk_out);

    // 1: o_in=01, pattern 000F, len 4, gap 0.
    o_force = 2'b01;
    begin_run(16'h000F, 5'd4, 4'd0);
    for (int k = 0; k < 4; k++) push_en(k + 1, 1, k, k, 1, (k > 0) ? 1 : -1);
    push_done(5, 4, 4, 1);
    finish_run(40);
    check("t1_busy_cycles", busy_cycles, 5);
    check("t1_hit_hold", int'(hit_count), 4);

    // 2: o_in=00, pattern bits 1,0,1, len 3, gap 2.
    o_force = 2'b00;
    begin_run(16'h0005, 5'd3, 4'd2);
    push_en(1, 1, 0, 0, 0, -1);
    push_en(4, 0, 1, 0, 0, 0);
    push_en(7, 1, 2, 0, 0, 0);
    push_done(10, 3, 0, 0);
    finish_run(40);
    check("t2_busy_cycles", busy_cycles, 10);
    check("t2_step_idx", int'(step_idx), 3);

    // 3: zero length: done straight away.
    begin_run(16'hFFFF, 5'd0, 4'd3);
    push_done(1, 0, 0, -1);
    finish_run(40);
    check("t3_busy_cycles", busy_cycles, 1);

    // 4: len 31 clamps to 16.
    o_force = 2'b01;
    p = 16'hA5C3;
    begin_run(p, 5'd31, 4'd0);
    for (int k = 0; k < 16; k++) push_en(k + 1, int'(p[k]), k, k, 1, (k > 0) ? 1 : -1);
    push_done(17, 16, 16, 1);
    finish_run(60);
    check("t4_busy_cycles", busy_cycles, 17);

    // 5: abort during cycle 3 of a len=8 run; start mid-run is ignored.
    begin_run(16'h00FF, 5'd8, 4'd0);
    push_en(1, 1, 0, 0, 1, -1);
    push_en(2, 1, 1, 1, 1, 1);
    @(negedge clk_out);               // cycle 1
    start = 1'b0;
    @(negedge clk_out);               // cycle 2
    start = 1'b1; run_len = 5'd1; pattern = 16'h0000;
    @(posedge clk_out); #1;           // cycle 3
    start = 1'b0; abort = 1'b1;
    @(posedge clk_out); #1;           // cycle 4
    abort = 1'b0;
    check("t5_busy", int'(busy), 0);
    check("t5_hit_count", int'(hit_count), 2);
    check("t5_step_idx", int'(step_idx), 2);
    check("t5_last_o", int'(last_o), 1);
    repeat (3) @(negedge clk_out);
    check("t5_busy_cycles", busy_cycles, 3);

    // 6: closed loop with the FSM model, pattern 0101, gap 1.
    loop_mode = 1'b1;
    fsm_rst = 1'b1; #1; fsm_rst = 1'b0;
    begin_run(16'h0005, 5'd4, 4'd1);
    push_en(1, 1, 0, 0, 0, -1);
    push_en(3, 0, 1, 0, 1, 0);
    push_en(5, 1, 2, 1, 2, 1);
    push_en(7, 0, 3, 1, 1, 2);
    push_done(9, 4, 2, 1);
    finish_run(40);
    loop_mode = 1'b0;
    check("t6_busy_cycles", busy_cycles, 9);

    // 7: asynchronous reset mid-run clears all outputs at once.
    o_force = 2'b01;
    begin_run(16'hFFFF, 5'd10, 4'd0);
    push_en(1, 1, 0, 0, 1, -1);
    push_en(2, 1, 1, 1, 1, 1);
    @(negedge clk_out);
    start = 1'b0;
    @(negedge clk_out);
    #1 reset = 1'b1;
    #1;
    check("t7_busy", int'(busy), 0);
    check("t7_fsm_en", int'(fsm_en), 0);
    check("t7_step_idx", int'(step_idx), 0);
    check("t7_hit_count", int'(hit_count), 0);
    check("t7_last_o", int'(last_o), 0);
    @(negedge clk_out);
    reset = 1'b0;

    repeat (3) @(negedge clk_out);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
